// File: rtl/h_bridge_deadtime_if.sv
// Signal bundle between the PWM H-bridge source and the dead-time stage.
// The master drives the requests and control; the slave (the dead-time stage) drives the pin outputs.
interface h_bridge_deadtime_if #(
    parameter int unsigned DT_WIDTH = 8
);
    logic                in_1;
    logic                in_2;
    logic                enable;
    logic [DT_WIDTH-1:0] dead_time;
    logic                nFault_in;
    logic                fault_clear;
    logic                drv_1;
    logic                drv_2;
    logic                fault_latched;
    logic                in_dead;

    modport master (
        output in_1, in_2, enable, dead_time, nFault_in, fault_clear,
        input  drv_1, drv_2, fault_latched, in_dead
    );

    modport slave (
        input  in_1, in_2, enable, dead_time, nFault_in, fault_clear,
        output drv_1, drv_2, fault_latched, in_dead
    );
endinterface

// File: rtl/h_bridge_deadtime.sv
// H-bridge dead-time inserter: forces a both-low gap between opposing leg patterns
// and latches driver faults until they are cleared by software.
module h_bridge_deadtime #(
    parameter int unsigned DT_WIDTH    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    h_bridge_deadtime_if.slave bus
);
    typedef enum logic [1:0] {S_OFF, S_ACTIVE, S_DEAD, S_FAULT} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cur_q, cur_d;
    logic [1:0]             target_q, target_d;
    logic [DT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   in_dead_q, in_dead_d;
    logic                   fault_q, fault_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   nfault_s;
    logic [1:0]             req;

    assign req      = {bus.in_1, bus.in_2};
    assign nfault_s = sync_q[SYNC_STAGES-1];

    // Synchroniser idles high so a reset never looks like a fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.nFault_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_OFF;
            cur_q     <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            in_dead_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            in_dead_q <= in_dead_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        in_dead_d = in_dead_q;
        fault_d   = fault_q;

        if (!nfault_s) begin
            state_d   = S_FAULT;
            cur_d     = '0;
            cnt_d     = '0;
            in_dead_d = 1'b0;
            fault_d   = 1'b1;
        end else if (state_q == S_FAULT) begin
            if (bus.fault_clear) begin
                state_d = S_OFF;
                fault_d = 1'b0;
            end
        end else if (!bus.enable) begin
            state_d   = S_OFF;
            cur_d     = '0;
            cnt_d     = '0;
            in_dead_d = 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (req != 2'b00) begin
                        state_d = S_ACTIVE;
                        cur_d   = req;
                    end
                end
                S_ACTIVE: begin
                    if (req == cur_q) begin
                        state_d = S_ACTIVE;
                    end else if (req == 2'b00) begin
                        state_d = S_OFF;
                        cur_d   = '0;
                    end else if (bus.dead_time == '0) begin
                        cur_d = req;
                    end else begin
                        // Loading dead_time-1 makes the 00 gap exactly dead_time cycles long.
                        state_d   = S_DEAD;
                        cur_d     = '0;
                        cnt_d     = bus.dead_time - DT_WIDTH'(1);
                        target_d  = req;
                        in_dead_d = 1'b1;
                    end
                end
                S_DEAD: begin
                    target_d = req;
                    if (req == 2'b00) begin
                        state_d   = S_OFF;
                        cnt_d     = '0;
                        in_dead_d = 1'b0;
                    end else if (cnt_q == '0) begin
                        state_d   = S_ACTIVE;
                        cur_d     = target_q;
                        in_dead_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    assign bus.drv_1         = cur_q[1];
    assign bus.drv_2         = cur_q[0];
    assign bus.in_dead       = in_dead_q;
    assign bus.fault_latched = fault_q;
endmodule

// File: tb/tb_h_bridge_deadtime.sv
// Directed bench for h_bridge_deadtime: pass-through, dead-time gaps, fault latch and async reset.
module tb_h_bridge_deadtime;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    h_bridge_deadtime_if #(.DT_WIDTH(8)) bus ();

    h_bridge_deadtime #(.DT_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] drv, input logic dead, input logic flt);
        chk({tag, ".drv"},   {6'd0, bus.drv_1, bus.drv_2}, {6'd0, drv});
        chk({tag, ".dead"},  {7'd0, bus.in_dead},          {7'd0, dead});
        chk({tag, ".fault"}, {7'd0, bus.fault_latched},    {7'd0, flt});
    endtask

    // One clock step; also guards against a direct swap between two non-off patterns.
    task automatic tick();
        logic [1:0] prev;
        logic [1:0] now;
        prev = {bus.drv_1, bus.drv_2};
        @(posedge clk);
        #1;
        now = {bus.drv_1, bus.drv_2};
        if (bus.dead_time != 8'd0 && prev != 2'b00) begin
            n_cmp++;
            assert (now == 2'b00 || now == prev) else begin
                n_err++;
                $error("FAIL adjacent: observed %b after %b, required 00 or %b", now, prev, prev);
            end
        end
    endtask

    task automatic set_req(input logic [1:0] r);
        bus.in_1 = r[1];
        bus.in_2 = r[0];
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        set_req(2'b00);
        bus.enable      = 1'b0;
        bus.dead_time   = 8'd5;
        bus.nFault_in   = 1'b1;
        bus.fault_clear = 1'b0;
        #5;
        chk_out("reset", 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.enable = 1'b1;

        // Basic pass-through
        set_req(2'b10);
        chk_out("pre_pass", 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("pass_10", 2'b10, 1'b0, 1'b0);
        set_req(2'b00);
        tick();
        chk_out("pass_00", 2'b00, 1'b0, 1'b0);

        // Direction reversal, 5-cycle gap
        set_req(2'b10);
        tick();
        chk_out("rev_start", 2'b10, 1'b0, 1'b0);
        set_req(2'b01);
        tick();
        chk_out("rev_gap1", 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("rev_gap", 2'b00, 1'b1, 1'b0);
        end
        tick();
        chk_out("rev_end", 2'b01, 1'b0, 1'b0);

        // Target change during an 8-cycle gap; mid-gap dead_time change ignored
        bus.dead_time = 8'd8;
        set_req(2'b00);
        tick();
        set_req(2'b10);
        tick();
        chk_out("tgt_start", 2'b10, 1'b0, 1'b0);
        set_req(2'b01);
        tick();
        chk_out("tgt_gap1", 2'b00, 1'b1, 1'b0);
        tick();
        set_req(2'b11);
        bus.dead_time = 8'd20;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out("tgt_gap", 2'b00, 1'b1, 1'b0);
        end
        bus.dead_time = 8'd8;
        tick();
        chk_out("tgt_end", 2'b11, 1'b0, 1'b0);

        // Request drops to off mid-gap
        set_req(2'b01);
        tick();
        chk_out("drop_gap1", 2'b00, 1'b1, 1'b0);
        tick();
        tick();
        set_req(2'b00);
        tick();
        chk_out("drop_off", 2'b00, 1'b0, 1'b0);
        set_req(2'b10);
        tick();
        chk_out("drop_restart", 2'b10, 1'b0, 1'b0);

        // Zero dead-time
        bus.dead_time = 8'd0;
        set_req(2'b01);
        tick();
        chk_out("zero_01", 2'b01, 1'b0, 1'b0);
        set_req(2'b11);
        tick();
        chk_out("zero_11", 2'b11, 1'b0, 1'b0);
        set_req(2'b01);
        tick();
        chk_out("zero_back", 2'b01, 1'b0, 1'b0);
        bus.dead_time = 8'd5;

        // Fault: one-cycle low pulse, latency SYNC_STAGES+1 edges
        bus.nFault_in = 1'b0;
        tick();
        bus.nFault_in = 1'b1;
        chk_out("flt_e1", 2'b01, 1'b0, 1'b0);
        tick();
        chk_out("flt_e2", 2'b01, 1'b0, 1'b0);
        tick();
        chk_out("flt_e3", 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        chk_out("flt_sticky", 2'b00, 1'b0, 1'b1);

        // Clear while nFault still low is ignored
        bus.nFault_in = 1'b0;
        tick();
        tick();
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        chk_out("clr_ignored", 2'b00, 1'b0, 1'b1);
        bus.enable = 1'b0;
        tick();
        chk_out("en0_in_fault", 2'b00, 1'b0, 1'b1);
        bus.enable = 1'b1;

        // Clear with nFault high
        bus.nFault_in = 1'b1;
        tick();
        tick();
        tick();
        chk_out("no_clr", 2'b00, 1'b0, 1'b1);
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        chk_out("clr_ok", 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("post_clr", 2'b01, 1'b0, 1'b0);

        // enable=0 forces off from a gap
        set_req(2'b10);
        tick();
        chk_out("en_gap", 2'b00, 1'b1, 1'b0);
        bus.enable = 1'b0;
        tick();
        chk_out("en_off", 2'b00, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick();
        chk_out("en_resume", 2'b10, 1'b0, 1'b0);

        // Async reset during a gap
        set_req(2'b01);
        tick();
        tick();
        chk_out("rst_gap", 2'b00, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk_out("rst_async", 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("rst_hold", 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_out("rst_release", 2'b01, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
